// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the pipeline front end: opcodes, the fetch-queue
// entry layout and small decode helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // Sign-extended J-type immediate; bit 0 is always zero.
    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// Head data reads as zero when the queue is empty.
module fetch_queue #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_MAX);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the I-cache, predecodes
// JAL to follow direct jumps, and buffers fetched words in a fetch queue.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned FQ_DEPTH      = 4,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          BYTE_SWAP     = 1'b1,
    parameter bit          PREDECODE_JAL = 1'b1,
    localparam int unsigned CNT_W        = $clog2(FQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ICACHE_ren,
    output logic              ICACHE_wen,
    output logic [29:0]       ICACHE_addr,
    output logic [31:0]       ICACHE_wdata,
    input  logic              ICACHE_stall,
    input  logic [31:0]       ICACHE_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic              inst_pred_taken,
    output logic [CNT_W-1:0]  fq_count,
    output logic [31:0]       PC
);

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] fetched_word;
    logic        is_jal;
    logic        complete;
    logic        fq_full;
    logic        fq_empty;
    logic        unused_rpc_bits;
    fq_entry_t   push_entry;
    fq_entry_t   head_entry;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign fetched_word = BYTE_SWAP ? byte_swap(ICACHE_rdata) : ICACHE_rdata;
    assign is_jal       = PREDECODE_JAL && (fetched_word[6:0] == OPC_JAL);

    // Gated by rst_n so nothing is requested while reset is held.
    assign ICACHE_ren   = rst_n & ~fq_full & ~redirect_valid;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;
    assign ICACHE_addr  = fetch_pc_q[31:2];
    assign complete     = ICACHE_ren & ~ICACHE_stall;
    assign PC           = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (complete) begin
            fetch_pc_d = is_jal ? (fetch_pc_q + j_imm(fetched_word)) : (fetch_pc_q + 32'd4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign push_entry = '{pred: is_jal, pc: fetch_pc_q, inst: fetched_word};

    fetch_queue #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (complete),
        .push_data (push_entry),
        .pop       (inst_valid & inst_ready),
        .head_data (head_entry),
        .count     (fq_count),
        .empty     (fq_empty),
        .full      (fq_full)
    );

    assign inst_valid      = ~fq_empty;
    assign inst_data       = head_entry.inst;
    assign inst_pc         = head_entry.pc;
    assign inst_pred_taken = head_entry.pred;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch front end.
module tb_riscv_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ICACHE_ren, ICACHE_wen, ICACHE_stall;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_wdata, ICACHE_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready, inst_pred_taken;
    logic [31:0] inst_data, inst_pc, PC;
    logic [2:0]  fq_count;

    logic        ren1, wen1, stall1, r1, valid1, ready1, pred1;
    logic [29:0] addr1;
    logic [31:0] wdata1, rdata1, rp1, data1, ipc1, pc1;
    logic [2:0]  cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] mpc;
    logic [31:0] ovr [logic [31:0]];

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .FQ_DEPTH      (DEPTH),
        .RESET_PC      (32'h0),
        .BYTE_SWAP     (1'b1),
        .PREDECODE_JAL (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ICACHE_ren      (ICACHE_ren),
        .ICACHE_wen      (ICACHE_wen),
        .ICACHE_addr     (ICACHE_addr),
        .ICACHE_wdata    (ICACHE_wdata),
        .ICACHE_stall    (ICACHE_stall),
        .ICACHE_rdata    (ICACHE_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_pred_taken (inst_pred_taken),
        .fq_count        (fq_count),
        .PC              (PC)
    );

    riscv_fetch_unit #(
        .FQ_DEPTH      (DEPTH),
        .RESET_PC      (32'h0),
        .BYTE_SWAP     (1'b0),
        .PREDECODE_JAL (1'b0)
    ) dut_plain (
        .clk             (clk),
        .rst_n           (rst_n),
        .ICACHE_ren      (ren1),
        .ICACHE_wen      (wen1),
        .ICACHE_addr     (addr1),
        .ICACHE_wdata    (wdata1),
        .ICACHE_stall    (stall1),
        .ICACHE_rdata    (rdata1),
        .redirect_valid  (r1),
        .redirect_pc     (rp1),
        .inst_valid      (valid1),
        .inst_ready      (ready1),
        .inst_data       (data1),
        .inst_pc         (ipc1),
        .inst_pred_taken (pred1),
        .fq_count        (cnt1),
        .PC              (pc1)
    );

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Program image: addi x1,x1,<addr bits> everywhere unless overridden.
    function automatic logic [31:0] img(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] mk_jal(input int off);
        logic [20:0] im;
        im = 21'(off);
        return {im[20], im[10:1], im[11], im[19:12], 5'd0, 7'h6F};
    endfunction

    function automatic logic [31:0] head_data();
        return (mq.size() != 0) ? mq[0].data : 32'h0;
    endfunction

    function automatic logic [31:0] head_pc();
        return (mq.size() != 0) ? mq[0].pc : 32'h0;
    endfunction

    function automatic logic head_pred();
        return (mq.size() != 0) ? mq[0].pred : 1'b0;
    endfunction

    task automatic set_in(input logic r, input logic [31:0] rp, input logic st, input logic rd);
        redirect_valid = r;
        redirect_pc    = rp;
        ICACHE_stall   = st;
        inst_ready     = rd;
        ICACHE_rdata   = bswap(img(mpc));
    endtask

    // Advance one clock and apply the fetch rules to the model.
    task automatic advance();
        logic [31:0] w;
        int          sz;
        @(posedge clk);
        if (rst_n) begin
            sz = mq.size();
            if (redirect_valid) begin
                mq.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (sz > 0 && inst_ready) void'(mq.pop_front());
                if (sz < DEPTH && !ICACHE_stall) begin
                    w = img(mpc);
                    if (w[6:0] == 7'b1101111) begin
                        mq.push_back('{data: w, pc: mpc, pred: 1'b1});
                        mpc = mpc + jimm(w);
                    end else begin
                        mq.push_back('{data: w, pc: mpc, pred: 1'b0});
                        mpc = mpc + 32'd4;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r1 = 1'b0; rp1 = '0; stall1 = 1'b0; ready1 = 1'b1; rdata1 = 32'h13;
        mq.delete();
        mpc = 32'h0;
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b exp 0", ICACHE_ren); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fq_count); end
        n_tests++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", PC); end
        n_tests++; if ({inst_data, inst_pc, inst_pred_taken} !== 65'h0) begin
            n_fail++; $display("FAIL reset_head got %h/%h/%b exp 0", inst_data, inst_pc, inst_pred_taken);
        end
        n_tests++; if (ren1 !== 1'b0) begin n_fail++; $display("FAIL reset_ren_plain got %b exp 0", ren1); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1);
            @(negedge clk);
            n_tests++; if (ICACHE_addr !== 30'(k)) begin
                n_fail++; $display("FAIL stream_addr k=%0d got %h exp %h", k, ICACHE_addr, k);
            end
            n_tests++; if (inst_valid !== (k > 0)) begin
                n_fail++; $display("FAIL stream_valid k=%0d got %b exp %b", k, inst_valid, k > 0);
            end
            if (k > 0) begin
                n_tests++; if (inst_pc !== 32'((k - 1) * 4) || inst_data !== img(32'((k - 1) * 4))) begin
                    n_fail++; $display("FAIL stream_head k=%0d got pc %h data %h exp pc %h", k, inst_pc,
                                       inst_data, (k - 1) * 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 32'h300, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (c >= 4) begin
                n_tests++; if (fq_count !== 3'd4 || ICACHE_ren !== 1'b0 || PC !== 32'h310) begin
                    n_fail++; $display("FAIL bp_full c=%0d got cnt %0d ren %b pc %h exp 4 0 310", c, fq_count,
                                       ICACHE_ren, PC);
                end
            end
            advance();
        end
        for (int d = 0; d < 5; d++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1);
            @(negedge clk);
            n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300 + 32'(4 * d)) begin
                n_fail++; $display("FAIL bp_order d=%0d got v %b pc %h exp pc %h", d, inst_valid, inst_pc,
                                   32'h300 + 32'(4 * d));
            end
            if (d == 0) begin
                n_tests++; if (ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL bp_no_spec got ren %b exp 0", ICACHE_ren); end
            end
            if (d == 1) begin
                n_tests++; if (fq_count !== 3'd3 || ICACHE_ren !== 1'b1) begin
                    n_fail++; $display("FAIL bp_resume got cnt %0d ren %b exp 3 1", fq_count, ICACHE_ren);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 32'h10, 1'b0, 1'b1);
        advance();
        for (int s = 0; s < 4; s++) begin
            set_in(1'b0, 32'h0, s < 3, 1'b1);
            @(negedge clk);
            n_tests++; if (ICACHE_addr !== 30'h4 || fq_count !== 3'd0 || ICACHE_ren !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold s=%0d got addr %h cnt %0d ren %b exp 4 0 1", s, ICACHE_addr,
                                   fq_count, ICACHE_ren);
            end
            advance();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_data !== img(32'h10)) begin
            n_fail++; $display("FAIL stall_push got v %b pc %h data %h exp pc 10", inst_valid, inst_pc, inst_data);
        end
        advance();
    endtask

    task automatic test_redirect_mid_stall();
        bit seen_first;
        set_in(1'b1, 32'h38, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 2; c++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            advance();
        end
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (ICACHE_addr !== 30'h10 || fq_count !== 3'd2) begin
            n_fail++; $display("FAIL mid_setup got addr %h cnt %0d exp 10 2", ICACHE_addr, fq_count);
        end
        advance();
        set_in(1'b1, 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (ICACHE_ren !== 1'b0) begin n_fail++; $display("FAIL mid_ren got %b exp 0", ICACHE_ren); end
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b0 || fq_count !== 3'd0 || ICACHE_addr !== 30'h80) begin
            n_fail++; $display("FAIL mid_flush got v %b cnt %0d addr %h exp 0 0 80", inst_valid, fq_count,
                               ICACHE_addr);
        end
        seen_first = 1'b0;
        for (int c = 0; c < 4; c++) begin
            advance();
            set_in(1'b0, 32'h0, 1'b0, 1'b1);
            @(negedge clk);
            if (inst_valid) begin
                n_tests++; if (inst_pc === 32'h40 || (!seen_first && inst_pc !== 32'h200)) begin
                    n_fail++; $display("FAIL mid_deliver c=%0d got pc %h exp first 200 never 40", c, inst_pc);
                end
                seen_first = 1'b1;
            end
        end
        advance();
    endtask

    task automatic test_redirect_completion();
        set_in(1'b1, 32'h0, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 2; c++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
            advance();
        end
        set_in(1'b1, 32'h400, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (ICACHE_ren !== 1'b0 || ICACHE_addr !== 30'h2) begin
            n_fail++; $display("FAIL rc_ren got ren %b addr %h exp 0 2", ICACHE_ren, ICACHE_addr);
        end
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (fq_count !== 3'd0 || ICACHE_addr !== 30'h100) begin
            n_fail++; $display("FAIL rc_flush got cnt %0d addr %h exp 0 100", fq_count, ICACHE_addr);
        end
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400) begin
            n_fail++; $display("FAIL rc_first got v %b pc %h exp 1 400", inst_valid, inst_pc);
        end
        advance();
    endtask

    task automatic test_jal();
        ovr[32'h100] = 32'hFF1FF06F;
        set_in(1'b1, 32'h100, 1'b0, 1'b1);
        r1 = 1'b1; rp1 = 32'h100;
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        r1 = 1'b0; rdata1 = 32'hFF1FF06F;
        @(negedge clk);
        n_tests++; if (addr1 !== 30'h40) begin n_fail++; $display("FAIL jal_plain_addr got %h exp 40", addr1); end
        advance();
        rdata1 = 32'h13;
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (ICACHE_addr !== 30'h3C || PC !== 32'hF0) begin
            n_fail++; $display("FAIL jal_target got addr %h pc %h exp 3c f0", ICACHE_addr, PC);
        end
        n_tests++; if (inst_pc !== 32'h100 || inst_pred_taken !== 1'b1 || inst_data !== 32'hFF1FF06F) begin
            n_fail++; $display("FAIL jal_head got pc %h pred %b data %h exp 100 1 ff1ff06f", inst_pc,
                               inst_pred_taken, inst_data);
        end
        n_tests++; if (pc1 !== 32'h104 || pred1 !== 1'b0 || data1 !== 32'hFF1FF06F || ipc1 !== 32'h100) begin
            n_fail++; $display("FAIL jal_plain got pc %h pred %b data %h ipc %h exp 104 0 ff1ff06f 100", pc1,
                               pred1, data1, ipc1);
        end
        advance();
    endtask

    task automatic test_byte_swap();
        ovr[32'h500] = 32'h00000013;
        set_in(1'b1, 32'h500, 1'b0, 1'b1);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (inst_data !== 32'h00000013 || inst_pc !== 32'h500) begin
            n_fail++; $display("FAIL bswap got data %h pc %h exp 00000013 500", inst_data, inst_pc);
        end
        advance();
    endtask

    task automatic test_random();
        logic        r, st, rd;
        logic [31:0] rp;
        int          off;
        for (int i = 0; i < 6; i++) begin
            off = 4 * $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 1) off = -off;
            ovr[32'($urandom_range(0, 255)) << 2] = mk_jal(off);
        end
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 99) < 5);
            rp = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 60);
            set_in(r, rp, st, rd);
            @(negedge clk);
            n_tests++; if (ICACHE_ren !== (mq.size() < DEPTH && !r)) begin
                n_fail++; $display("FAIL rnd_ren c=%0d got %b exp %b", c, ICACHE_ren, mq.size() < DEPTH && !r);
            end
            n_tests++; if (ICACHE_addr !== mpc[31:2] || PC !== mpc) begin
                n_fail++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, PC, mpc);
            end
            n_tests++; if (fq_count !== 3'(mq.size())) begin
                n_fail++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, fq_count, mq.size());
            end
            n_tests++; if (inst_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, inst_valid, mq.size() != 0);
            end
            n_tests++; if (inst_data !== head_data() || inst_pc !== head_pc()
                           || inst_pred_taken !== head_pred()) begin
                n_fail++; $display("FAIL rnd_head c=%0d got %h/%h/%b exp %h/%h/%b", c, inst_data, inst_pc,
                                   inst_pred_taken, head_data(), head_pc(), head_pred());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_redirect_mid_stall();
        test_redirect_completion();
        test_jal();
        test_byte_swap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
